debounce_sync: RTL and testbench
================================

Name: debounce_sync

Overview:
- Upstream conditioning stage for the team's latch/flip-flop storage cells.
- Takes a raw, asynchronous, bouncy input (push-button or switch) and synchronises it into the `clk` domain.
- Rejects glitches shorter than a programmable stable window.
- Delivers a clean registered level plus one-cycle rise/fall pulses; the clean level drives the `d` input of the downstream D flip-flops.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flip-flops; legal range 2..4.
- CNT_WIDTH, 8, width of the stability counter.
- STABLE_CNT, 200, number of qualifying ticks the synchronised input must hold before the output changes; legal range 1..2^CNT_WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn_in  input  1  raw asynchronous input; no timing relationship to `clk`.
- tick  input  1  sample enable for the stability counter; tie to 1 to count every clock.
- q_level  output  1  debounced registered level.
- rise_pulse  output  1  high for exactly one clock when `q_level` goes 0->1.
- fall_pulse  output  1  high for exactly one clock when `q_level` goes 1->0.
- busy  output  1  high while a candidate transition is being qualified.

Behaviour:
- Reset: `clk` with one clock domain; `rst_n` is asynchronous, active-low.
  - While `rst_n`=0, clear immediately, without waiting for a clock edge: all synchroniser stages, counter, `q_level`, `rise_pulse`, `fall_pulse`, `busy` go to 0; FSM goes to IDLE_LOW.
- Synchroniser: shift chain of SYNC_STAGES flops.
  - `s` = last stage.
  - Only `s` is used by the logic; `btn_in` is never sampled elsewhere.
- FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
  - `q_level`=1 in IDLE_HIGH and WAIT_LOW; 0 otherwise.
  - `busy`=1 in WAIT_* states.
- IDLE_LOW: if `s`=1 -> WAIT_HIGH, counter<=0; else stay.
- IDLE_HIGH: if `s`=0 -> WAIT_LOW, counter<=0; else stay.
- WAIT_HIGH, evaluated in this priority order:
  1. `s`=0 (bounce) -> IDLE_LOW, counter<=0, no pulse.
  2. Else if `tick`=1 and counter==STABLE_CNT-1 -> IDLE_HIGH, `rise_pulse`<=1.
  3. Else if `tick`=1 -> counter<=counter+1.
  4. Else hold.
- WAIT_LOW: mirror of WAIT_HIGH with `s`=1 as the bounce condition and `fall_pulse` as the pulse.
- Bounce check wins over `tick` in the same cycle.
- Counter:
  - Unsigned, CNT_WIDTH bits.
  - Never exceeds STABLE_CNT-1, so it cannot wrap.
  - Cleared on every state entry.
- Pulses: registered.
  - Deasserted the cycle after assertion.
  - `rise_pulse` and `fall_pulse` are never high together.
  - The pulse is asserted in the same cycle `q_level` changes.
- Latency (`tick`=1, `btn_in` steps and stays before edge 1):
  - `s` changes after edge SYNC_STAGES.
  - FSM enters WAIT after edge SYNC_STAGES+1.
  - `q_level` and pulse change after edge SYNC_STAGES+STABLE_CNT+1.
- STABLE_CNT=1: transition commits on the first qualifying tick in WAIT.
- Reset mid-WAIT:
  - Abandons qualification; no pulse.
  - After release, a held-high `btn_in` is re-qualified from scratch and yields one `rise_pulse`.
- Input held stable: no further pulses; counter idle at 0.

Test Plan:
Common setup: SYNC_STAGES=2, STABLE_CNT=4, CNT_WIDTH=8, clk period 200, `tick`=1 unless stated.
1. Reset:
   - Stimulus: `rst_n`=0 at t=0 with `btn_in`=1; release after 2 clocks; hold `btn_in`=1.
   - Required response: all outputs 0 during reset; `q_level`=1 and `rise_pulse`=1 for one cycle after the 7th edge following release; `busy`=1 for 4 cycles before that.
2. Clean press then release:
   - Stimulus: `btn_in` 0->1, held 20 cycles; then 1->0.
   - Required response: `rise_pulse` once, `q_level`=1 after 7 edges; `fall_pulse` once, `q_level`=0 after 7 edges.
3. Bounce rejection:
   - Stimulus: `btn_in` toggles 1,0,1,0 every 2 cycles, then stays 0.
   - Required response: `q_level` stays 0, no pulses, `busy` pulses then returns to 0.
4. Bounce then settle:
   - Stimulus: `btn_in` toggles 3 times at 1-cycle spacing, then holds 1.
   - Required response: exactly one `rise_pulse`, 7 edges after the final 0->1.
5. Tick gating:
   - Stimulus: `tick` high every 3rd cycle; `btn_in` 0->1 held.
   - Required response: `q_level` rises only after 4 ticks in WAIT_HIGH; the counter holds on non-tick cycles.
6. Reset mid-operation:
   - Stimulus: assert `rst_n`=0 asynchronously (between edges) while `busy`=1 in WAIT_HIGH.
   - Required response: `busy`, counter and `q_level` go to 0 immediately; no `rise_pulse` until full re-qualification after release.

Source files
------------

// File: rtl/debounce_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : debounce_sync                                                   |
// | Brief    : Synchronise a bouncy async input, qualify it over a stable      |
// |            window, emit a clean level plus one-cycle rise/fall pulses.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module debounce_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 8,
    parameter int STABLE_CNT  = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    input  logic tick,
    output logic q_level,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    localparam logic [1:0] IDLE_LOW  = 2'd0;
    localparam logic [1:0] WAIT_HIGH = 2'd1;
    localparam logic [1:0] IDLE_HIGH = 2'd2;
    localparam logic [1:0] WAIT_LOW  = 2'd3;

    // Terminal count; STABLE_CNT may equal 2^CNT_WIDTH, so STABLE_CNT-1 still fits.
    localparam logic [CNT_WIDTH-1:0] C_CNT_LAST = CNT_WIDTH'(STABLE_CNT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [1:0]             state_q;
    logic [1:0]             state_d;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   cnt_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;
    logic                   s;

    assign sync_d[0] = btn_in;

    generate
        for (genvar i = 1; i < SYNC_STAGES; i++) begin : g_sync
            assign sync_d[i] = sync_q[i-1];
        end
    endgenerate

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // A bounce back to the committed level always beats a coincident tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            IDLE_LOW: begin
                if (s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == C_CNT_LAST) begin
                        state_d = IDLE_HIGH;
                        cnt_d   = '0;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            IDLE_HIGH: begin
                if (!s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == C_CNT_LAST) begin
                        state_d = IDLE_LOW;
                        cnt_d   = '0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        q_level    = (state_q == IDLE_HIGH) || (state_q == WAIT_LOW);
        busy       = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);
        rise_pulse = rise_q;
        fall_pulse = fall_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_debounce_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_debounce_sync                                                |
// | Brief    : Directed self-checking bench for debounce_sync.                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_debounce_sync;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_in;
    logic tick;
    logic q_level;
    logic rise_pulse;
    logic fall_pulse;
    logic busy;

    int checks     = 0;
    int failures   = 0;
    int rise_seen  = 0;
    int fall_seen  = 0;

    debounce_sync #(
        .SYNC_STAGES (2),
        .CNT_WIDTH   (8),
        .STABLE_CNT  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_in     (btn_in),
        .tick       (tick),
        .q_level    (q_level),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .busy       (busy)
    );

    always #100 clk = ~clk;

    // Advance one rising edge, sample 1 time unit later, tally pulses.
    task automatic step();
        @(posedge clk);
        #1;
        rise_seen += int'(rise_pulse);
        fall_seen += int'(fall_pulse);
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic apply_reset();
        rst_n  = 1'b0;
        btn_in = 1'b0;
        tick   = 1'b1;
        steps(2);
        rst_n = 1'b1;
        steps(3);
        rise_seen = 0;
        fall_seen = 0;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        btn_in = 1'b1;
        tick   = 1'b1;
        step();
        checks++;
        if ({q_level, rise_pulse, fall_pulse, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outs_1: got %b expected 0000", {q_level, rise_pulse, fall_pulse, busy});
        end
        step();
        checks++;
        if ({q_level, rise_pulse, fall_pulse, busy} !== 4'b0000 || dut.cnt_q !== 8'd0) begin
            failures++;
            $display("FAIL reset_outs_2: got %b cnt=%0d expected 0000 cnt=0",
                     {q_level, rise_pulse, fall_pulse, busy}, dut.cnt_q);
        end
        rst_n     = 1'b1;
        rise_seen = 0;
        fall_seen = 0;
        steps(2);
        checks++;
        if ({q_level, busy} !== 2'b00) begin
            failures++;
            $display("FAIL reset_sync_lat: got q/busy=%b expected 00", {q_level, busy});
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({q_level, busy} !== 2'b01) begin
                failures++;
                $display("FAIL reset_busy_%0d: got q/busy=%b expected 01", i, {q_level, busy});
            end
        end
        step();
        checks++;
        if ({q_level, rise_pulse, busy} !== 3'b110) begin
            failures++;
            $display("FAIL reset_rise: got q/rise/busy=%b expected 110", {q_level, rise_pulse, busy});
        end
        step();
        checks++;
        if ({q_level, rise_pulse} !== 2'b10 || rise_seen != 1) begin
            failures++;
            $display("FAIL reset_rise_once: got q/rise=%b count=%0d expected 10 count=1",
                     {q_level, rise_pulse}, rise_seen);
        end
    endtask

    task automatic test_press_release();
        apply_reset();
        btn_in = 1'b1;
        steps(6);
        checks++;
        if ({q_level, busy} !== 2'b01 || rise_seen != 0) begin
            failures++;
            $display("FAIL press_pre: got q/busy=%b rises=%0d expected 01 rises=0", {q_level, busy}, rise_seen);
        end
        step();
        checks++;
        if ({q_level, rise_pulse, fall_pulse} !== 3'b110) begin
            failures++;
            $display("FAIL press_edge: got q/rise/fall=%b expected 110", {q_level, rise_pulse, fall_pulse});
        end
        steps(13);
        checks++;
        if ({q_level, busy} !== 2'b10 || dut.cnt_q !== 8'd0 || rise_seen != 1 || fall_seen != 0) begin
            failures++;
            $display("FAIL press_hold: got q/busy=%b cnt=%0d rises=%0d falls=%0d expected 10 cnt=0 rises=1 falls=0",
                     {q_level, busy}, dut.cnt_q, rise_seen, fall_seen);
        end
        btn_in = 1'b0;
        steps(6);
        checks++;
        if ({q_level, busy, fall_pulse} !== 3'b110) begin
            failures++;
            $display("FAIL release_pre: got q/busy/fall=%b expected 110", {q_level, busy, fall_pulse});
        end
        step();
        checks++;
        if ({q_level, rise_pulse, fall_pulse} !== 3'b001) begin
            failures++;
            $display("FAIL release_edge: got q/rise/fall=%b expected 001", {q_level, rise_pulse, fall_pulse});
        end
        step();
        checks++;
        if (fall_pulse !== 1'b0) begin
            failures++;
            $display("FAIL release_pulse_width: got fall=%b expected 0", fall_pulse);
        end
        steps(10);
        checks++;
        if (fall_seen != 1 || rise_seen != 1 || busy !== 1'b0 || q_level !== 1'b0) begin
            failures++;
            $display("FAIL release_settled: got falls=%0d rises=%0d busy=%b q=%b expected 1 1 0 0",
                     fall_seen, rise_seen, busy, q_level);
        end
    endtask

    task automatic test_bounce_reject();
        logic [3:0] pattern;
        logic       busy_seen;
        apply_reset();
        pattern   = 4'b1010;
        busy_seen = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            btn_in = pattern[i];
            repeat (2) begin
                step();
                busy_seen |= busy;
            end
        end
        btn_in = 1'b0;
        steps(12);
        checks++;
        if (busy_seen !== 1'b1) begin
            failures++;
            $display("FAIL bounce_busy_seen: got %b expected 1", busy_seen);
        end
        checks++;
        if ({q_level, busy} !== 2'b00 || rise_seen != 0 || fall_seen != 0) begin
            failures++;
            $display("FAIL bounce_reject: got q/busy=%b rises=%0d falls=%0d expected 00 0 0",
                     {q_level, busy}, rise_seen, fall_seen);
        end
    endtask

    task automatic test_bounce_settle();
        apply_reset();
        btn_in = 1'b1;
        step();
        btn_in = 1'b0;
        step();
        btn_in = 1'b1;
        steps(6);
        checks++;
        if (q_level !== 1'b0 || rise_seen != 0) begin
            failures++;
            $display("FAIL settle_pre: got q=%b rises=%0d expected 0 0", q_level, rise_seen);
        end
        step();
        checks++;
        if ({q_level, rise_pulse} !== 2'b11) begin
            failures++;
            $display("FAIL settle_edge: got q/rise=%b expected 11", {q_level, rise_pulse});
        end
        steps(5);
        checks++;
        if (rise_seen != 1 || fall_seen != 0 || q_level !== 1'b1) begin
            failures++;
            $display("FAIL settle_once: got rises=%0d falls=%0d q=%b expected 1 0 1", rise_seen, fall_seen, q_level);
        end
    endtask

    task automatic test_tick_gating();
        apply_reset();
        tick   = 1'b0;
        btn_in = 1'b1;
        steps(3);
        checks++;
        if (busy !== 1'b1 || dut.cnt_q !== 8'd0) begin
            failures++;
            $display("FAIL tick_enter_wait: got busy=%b cnt=%0d expected 1 0", busy, dut.cnt_q);
        end
        for (int i = 0; i < 11; i++) begin
            tick = (i % 3 == 2);
            step();
            if (i == 4) begin
                checks++;
                if (dut.cnt_q !== 8'd1) begin
                    failures++;
                    $display("FAIL tick_hold_1: got cnt=%0d expected 1", dut.cnt_q);
                end
            end
            if (i == 7) begin
                checks++;
                if (dut.cnt_q !== 8'd2) begin
                    failures++;
                    $display("FAIL tick_hold_2: got cnt=%0d expected 2", dut.cnt_q);
                end
            end
        end
        checks++;
        if ({q_level, busy} !== 2'b01 || dut.cnt_q !== 8'd3) begin
            failures++;
            $display("FAIL tick_pre_commit: got q/busy=%b cnt=%0d expected 01 3", {q_level, busy}, dut.cnt_q);
        end
        tick = 1'b1;
        step();
        checks++;
        if ({q_level, rise_pulse, busy} !== 3'b110) begin
            failures++;
            $display("FAIL tick_commit: got q/rise/busy=%b expected 110", {q_level, rise_pulse, busy});
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        btn_in = 1'b1;
        steps(4);
        checks++;
        if (busy !== 1'b1 || dut.cnt_q !== 8'd1) begin
            failures++;
            $display("FAIL midrst_setup: got busy=%b cnt=%0d expected 1 1", busy, dut.cnt_q);
        end
        #50;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({q_level, busy, rise_pulse} !== 3'b000 || dut.cnt_q !== 8'd0) begin
            failures++;
            $display("FAIL midrst_async: got q/busy/rise=%b cnt=%0d expected 000 0",
                     {q_level, busy, rise_pulse}, dut.cnt_q);
        end
        steps(2);
        rst_n = 1'b1;
        steps(6);
        checks++;
        if (q_level !== 1'b0 || rise_seen != 0) begin
            failures++;
            $display("FAIL midrst_requal_pre: got q=%b rises=%0d expected 0 0", q_level, rise_seen);
        end
        step();
        checks++;
        if ({q_level, rise_pulse} !== 2'b11) begin
            failures++;
            $display("FAIL midrst_requal_edge: got q/rise=%b expected 11", {q_level, rise_pulse});
        end
        steps(3);
        checks++;
        if (rise_seen != 1 || fall_seen != 0) begin
            failures++;
            $display("FAIL midrst_once: got rises=%0d falls=%0d expected 1 0", rise_seen, fall_seen);
        end
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_bounce_reject();
        test_bounce_settle();
        test_tick_gating();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
